// File: rtl/imem_responder_if.sv
// ----------------------------------------------------------------------------
// imem_responder_if
//   Bundles the ifmap load port, the PPE request port, the PPE response port
//   and the status flags of the input-memory responder.
//
//   Load     : ld_valid / ld_ready, ld_row[4:0], ld_data[24:0]
//   Control  : start (1-cycle pulse)
//   Request  : in_valid / in_ready, in_data[32:0]
//              [32:29] dest, [28:25] opcode (PE address), [24:0] unused
//   Response : out_valid / out_ready, out_data[32:0]
//              [32:29] PE address, [28:25] opcode INPUT (1), [24:0] row bits
//   Status   : busy, done, err
//
//   master : the environment (ifmap loader, NoC port, controller)
//   slave  : the responder itself
// ----------------------------------------------------------------------------
interface imem_responder_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_row;
    logic [24:0] ld_data;

    logic        start;

    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_data;

    logic        out_valid;
    logic        out_ready;
    logic [32:0] out_data;

    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output ld_valid, ld_row, ld_data, start, in_valid, in_data, out_ready,
        input  ld_ready, in_ready, out_valid, out_data, busy, done, err
    );

    modport slave (
        input  ld_valid, ld_row, ld_data, start, in_valid, in_data, out_ready,
        output ld_ready, in_ready, out_valid, out_data, busy, done, err
    );
endinterface

// File: rtl/imem_responder.sv
// ----------------------------------------------------------------------------
// imem_responder
//   Input-memory (I_MEM) end of the PPE input-request protocol. Holds one
//   binary IFMAP_SIZE x IFMAP_SIZE ifmap. On start it pushes PPE k its first
//   row (row k), then answers every request from PPE k with that PPE's next
//   row (row k + cnt[k]) until each PPE has received OUTPUT_DIM rows.
//
//   Ports
//     clk    : clock, all logic on the rising edge
//     reset  : synchronous, active-high
//     bus    : imem_responder_if.slave (load, request, response, status)
//
//   Build option
//     IMEM_REQ_CHECK_EN : when defined, requests with a foreign dest, an
//       out-of-range PE or an exhausted PE, and loads with an out-of-range
//       row, raise the sticky err flag. When undefined, dest is not checked,
//       bad requests/loads are silently dropped and err is tied low.
// ----------------------------------------------------------------------------
module imem_responder #(
    parameter int IFMAP_SIZE  = 25,
    parameter int FILTER_SIZE = 5,
    parameter int NUM_PE      = 5,
    parameter int PE_BASE     = 5,
    parameter int IMEM_ID     = 10
) (
    input  logic            clk,
    input  logic            reset,
    imem_responder_if.slave bus
);
    localparam int OUTPUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
    localparam int CW         = $clog2(OUTPUT_DIM + 1);
    localparam int KW         = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int RW         = $clog2(IFMAP_SIZE);

    localparam logic [CW-1:0] CNT_MAX   = CW'(OUTPUT_DIM);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [KW-1:0] LAST_PE   = KW'(NUM_PE - 1);
    localparam logic [KW-1:0] K_ONE     = KW'(1);
    localparam logic [3:0]    PE_BASE_A = 4'(PE_BASE);
    localparam logic [4:0]    PE_END_A  = 5'(PE_BASE + NUM_PE);
    localparam logic [4:0]    ROW_LIM   = 5'(IFMAP_SIZE);
    localparam logic [3:0]    OP_INPUT  = 4'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SERVE,
        S_RESP,
        S_DONE
    } state_t;

    state_t                state;
    logic [IFMAP_SIZE-1:0] mem [IFMAP_SIZE];
    logic [CW-1:0]         cnt [NUM_PE];
    logic [KW-1:0]         init_k;      // PE currently being primed in INIT
    logic [KW-1:0]         cur_k;       // PE whose response is in flight

    logic [3:0]    req_op;
    logic [3:0]    req_k;
    logic          req_in_range;
    logic          req_live;
    logic [CW-1:0] req_cnt;
    logic [RW-1:0] req_row;
    logic [KW-1:0] init_k_next;
    logic [RW-1:0] init_row_next;
    logic          ld_fire;
    logic          ld_row_ok;
    logic          req_fire;
    logic          resp_fire;
    logic          start_ok;
    logic          last_resp;

    function automatic logic [32:0] make_pkt(input logic [3:0]            addr,
                                             input logic [IFMAP_SIZE-1:0] row);
        return {addr, OP_INPUT, 25'(row)};
    endfunction

    // ---------------------------------------------------------------- decode
    assign req_op       = bus.in_data[28:25];
    assign req_k        = req_op - PE_BASE_A;
    assign req_in_range = (req_op >= PE_BASE_A) && ({1'b0, req_op} < PE_END_A);

    // Row counter of the requesting PE; an out-of-range opcode reads as 0 and
    // is rejected by req_in_range anyway.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        req_cnt = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (req_k == 4'(k)) req_cnt = cnt[k];
        end
    end

    // PE k needs ifmap rows k .. k+OUTPUT_DIM-1, so its next row is k+cnt[k].
    assign req_row = RW'(req_k) + RW'(req_cnt);

`ifdef IMEM_REQ_CHECK_EN
    logic [3:0] req_dest;
    logic       unused_payload;
    assign req_dest       = bus.in_data[32:29];
    assign req_live       = req_in_range && (req_cnt != CNT_MAX) && (req_dest == 4'(IMEM_ID));
    assign unused_payload = ^bus.in_data[24:0];
`else
    logic unused_payload;
    assign req_live       = req_in_range && (req_cnt != CNT_MAX);
    assign unused_payload = ^{bus.in_data[32:29], bus.in_data[24:0]};
`endif

    assign init_k_next   = init_k + K_ONE;
    assign init_row_next = RW'(init_k_next);

    assign ld_row_ok = bus.ld_row < ROW_LIM;
    assign ld_fire   = !reset && bus.ld_valid && bus.ld_ready;
    assign req_fire  = bus.in_valid && bus.in_ready && (state == S_SERVE);
    assign resp_fire = bus.out_valid && bus.out_ready;
    assign start_ok  = bus.start && ((state == S_IDLE) || (state == S_DONE));

    // True when the response now completing brings every PE to OUTPUT_DIM.
    always_comb begin
        last_resp = 1'b1;
        for (int k = 0; k < NUM_PE; k++) begin
            if (KW'(k) == cur_k) begin
                if (cnt[k] != CNT_MAX - CNT_ONE) last_resp = 1'b0;
            end else if (cnt[k] != CNT_MAX) begin
                last_resp = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- ifmap
    // NOTE: the ifmap array is deliberately left out of reset: contents must
    // survive a reset, and an unreset array maps onto plain RAM/flop arrays.
    always_ff @(posedge clk) begin
        if (ld_fire && ld_row_ok) begin
            mem[bus.ld_row[RW-1:0]] <= bus.ld_data[IFMAP_SIZE-1:0];
        end
    end

    // ---------------------------------------------------------------- FSM
    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.in_ready  <= 1'b0;
            bus.ld_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            init_k        <= '0;
            cur_k         <= '0;
            for (int k = 0; k < NUM_PE; k++) cnt[k] <= '0;
`ifdef IMEM_REQ_CHECK_EN
            bus.err       <= 1'b0;
`endif
        end else begin
            if (start_ok) begin
                // New pass: clear progress and put row 0 for PE 0 on the wire.
                state         <= S_INIT;
                bus.ld_ready  <= 1'b0;
                bus.in_ready  <= 1'b0;
                bus.busy      <= 1'b1;
                bus.done      <= 1'b0;
                init_k        <= '0;
                for (int k = 0; k < NUM_PE; k++) cnt[k] <= '0;
                bus.out_valid <= 1'b1;
                bus.out_data  <= make_pkt(PE_BASE_A, mem[0]);
            end else begin
                case (state)
                    S_INIT: begin
                        if (resp_fire) begin
                            cnt[init_k] <= CNT_ONE;
                            if (init_k == LAST_PE) begin
                                state         <= S_SERVE;
                                bus.out_valid <= 1'b0;
                                bus.in_ready  <= 1'b1;
                            end else begin
                                init_k       <= init_k_next;
                                bus.out_data <= make_pkt(PE_BASE_A + 4'(init_k_next),
                                                         mem[init_row_next]);
                            end
                        end
                    end
                    S_SERVE: begin
                        if (req_fire && req_live) begin
                            state         <= S_RESP;
                            bus.in_ready  <= 1'b0;
                            bus.out_valid <= 1'b1;
                            bus.out_data  <= make_pkt(req_op, mem[req_row]);
                            cur_k         <= req_k[KW-1:0];
                        end
                    end
                    S_RESP: begin
                        if (resp_fire) begin
                            cnt[cur_k]    <= cnt[cur_k] + CNT_ONE;
                            bus.out_valid <= 1'b0;
                            if (last_resp) begin
                                state    <= S_DONE;
                                bus.done <= 1'b1;
                                bus.busy <= 1'b0;
                            end else begin
                                state        <= S_SERVE;
                                bus.in_ready <= 1'b1;
                            end
                        end
                    end
                    S_IDLE, S_DONE: begin
                    end
                    default: state <= S_IDLE;
                endcase
            end
`ifdef IMEM_REQ_CHECK_EN
            if ((ld_fire && !ld_row_ok) || (req_fire && !req_live)) bus.err <= 1'b1;
`endif
        end
    end

`ifndef IMEM_REQ_CHECK_EN
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// ----------------------------------------------------------------------------
// tb_imem_responder
//   Bench for imem_responder. The reference keeps its own copy of the ifmap
//   and one delivered-row count per PE; the expected response to a request
//   from PE k is simply {PE, INPUT, ifmap[k + count[k]]} while count[k] is
//   below OUTPUT_DIM. Build with +define+IMEM_REQ_CHECK_EN to exercise the
//   request-checking variant.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_responder;
    localparam int IFMAP_SIZE = 25;
    localparam int NUM_PE     = 5;
    localparam int PE_BASE    = 5;
    localparam int IMEM_ID    = 10;
    localparam int OUT_DIM    = 21;
`ifdef IMEM_REQ_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_responder_if bus ();

    imem_responder #(
        .IFMAP_SIZE (IFMAP_SIZE),
        .FILTER_SIZE(5),
        .NUM_PE     (NUM_PE),
        .PE_BASE    (PE_BASE),
        .IMEM_ID    (IMEM_ID)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0] dest;
        logic [3:0] op;
        bit         resp;   // a response is expected
        int         row;    // ifmap row carried by the response
        bit         err;    // expected err flag afterwards
    } vec_t;

    vec_t        vecs [6];
    int          errors = 0;
    int          checks = 0;
    int          resp_total = 0;
    bit          abort = 1'b0;
    logic [24:0] ref_mem [IFMAP_SIZE];
    int          ref_cnt [NUM_PE];
    bit          ref_err = 1'b0;
    bit          got;
    logic [32:0] data;
    logic [32:0] exp_pkt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic bit all_full();
        for (int k = 0; k < NUM_PE; k++) if (ref_cnt[k] != OUT_DIM) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load_row(input logic [4:0] row, input logic [24:0] val);
        bus.ld_valid = 1'b1;
        bus.ld_row   = row;
        bus.ld_data  = val;
        tick();
        bus.ld_valid = 1'b0;
        if (row < IFMAP_SIZE) ref_mem[row] = val;
    endtask

    // Pulse start and collect the five priming packets.
    task automatic run_init();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        check("init_busy", bus.busy, 1);
        check("init_ld_ready", bus.ld_ready, 0);
        check("init_done_clear", bus.done, 0);
        for (int c = 0; c < 30 && n < NUM_PE; c++) begin
            if (bus.out_valid) begin
                exp_pkt = {4'(PE_BASE + n), 4'd1, ref_mem[n]};
                check($sformatf("init_pkt%0d", n), bus.out_data, exp_pkt);
                ref_cnt[n] = 1;
                n++;
            end
            tick();
        end
        check("init_pkt_count", 33'(n), 33'(NUM_PE));
        bus.out_ready = 1'b0;
        check("serve_in_ready", bus.in_ready, 1);
        check("serve_out_valid", bus.out_valid, 0);
    endtask

    // Present one request; if answered, hold off out_ready for 'stall' cycles.
    task automatic send_req(input logic [3:0] dest, input logic [3:0] op, input int stall,
                            output bit rgot, output logic [32:0] rdata);
        int w;
        w = 0;
        rgot  = 1'b0;
        rdata = '0;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!bus.in_ready) begin
            check("req_wait_in_ready", bus.in_ready, 1);
            abort = 1'b1;
            return;
        end
        bus.in_data  = {dest, op, 25'($urandom)};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        rgot  = bus.out_valid;
        rdata = bus.out_data;
        if (rgot) begin
            repeat (stall) tick();
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    // Request checked against the reference model.
    task automatic model_req(input logic [3:0] dest, input logic [3:0] op, input int stall);
        int          k;
        bit          live;
        bit          rgot;
        logic [32:0] rdata;
        logic [32:0] rexp;
        k    = int'(op) - PE_BASE;
        live = (k >= 0) && (k < NUM_PE);
        if (live) live = ref_cnt[k] < OUT_DIM;
        if (CHK_EN && dest != 4'(IMEM_ID)) live = 1'b0;
        if (CHK_EN && !live) ref_err = 1'b1;
        rexp = '0;
        if (live) rexp = {op, 4'd1, ref_mem[k + ref_cnt[k]]};
        send_req(dest, op, stall, rgot, rdata);
        if (abort) return;
        check($sformatf("req_op%0d_valid", op), rgot, live);
        if (live) begin
            check($sformatf("req_op%0d_data", op), rdata, rexp);
            ref_cnt[k]++;
            resp_total++;
        end
        check("err_flag", bus.err, ref_err);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{dest: 4'd10, op: 4'd7,  resp: 1'b1,    row: 3, err: 1'b0};
        vecs[1] = '{dest: 4'd10, op: 4'd5,  resp: 1'b1,    row: 1, err: 1'b0};
        vecs[2] = '{dest: 4'd10, op: 4'd9,  resp: 1'b1,    row: 5, err: 1'b0};
        vecs[3] = '{dest: 4'd10, op: 4'd4,  resp: 1'b0,    row: 0, err: CHK_EN};
        vecs[4] = '{dest: 4'd10, op: 4'd12, resp: 1'b0,    row: 0, err: CHK_EN};
        vecs[5] = '{dest: 4'd3,  op: 4'd6,  resp: !CHK_EN, row: 2, err: CHK_EN};

        reset         = 1'b1;
        bus.ld_valid  = 1'b0;
        bus.ld_row    = '0;
        bus.ld_data   = '0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < NUM_PE; k++) ref_cnt[k] = 0;
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_ld_ready", bus.ld_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        reset = 1'b0;
        tick();

        // Load the one-hot ifmap and prime the PPEs.
        for (int i = 0; i < IFMAP_SIZE; i++) load_row(5'(i), 25'h1 << i);
        run_init();

        // Table of hand-derived requests.
        for (int i = 0; i < 6; i++) begin
            send_req(vecs[i].dest, vecs[i].op, 0, got, data);
            check($sformatf("vec%0d_resp", i), got, vecs[i].resp);
            if (vecs[i].resp) begin
                exp_pkt = {vecs[i].op, 4'd1, 25'h1 << vecs[i].row};
                check($sformatf("vec%0d_data", i), data, exp_pkt);
                ref_cnt[int'(vecs[i].op) - PE_BASE]++;
                resp_total++;
            end
            if (vecs[i].err) ref_err = 1'b1;
            check($sformatf("vec%0d_err", i), bus.err, vecs[i].err);
        end

        // PE 7 to exhaustion: rows up to 22, then one dropped request.
        for (int i = 0; i < 20 && !abort; i++) model_req(4'd10, 4'd7, 0);
        check("pe7_exhausted", 33'(ref_cnt[2]), 33'(OUT_DIM));

        // Back-pressure in RESP: response held stable, single handshake.
        bus.in_data  = {4'd10, 4'd6, 25'h0};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        exp_pkt = {4'd6, 4'd1, ref_mem[1 + ref_cnt[1]]};
        for (int c = 0; c < 5; c++) begin
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_out_data", bus.out_data, exp_pkt);
            check("stall_in_ready", bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("stall_release_valid", bus.out_valid, 0);
        check("stall_release_in_ready", bus.in_ready, 1);
        ref_cnt[1]++;
        resp_total++;

        // Randomized traffic until every PE has its OUTPUT_DIM rows.
        for (int it = 0; it < 2000 && !all_full() && !abort; it++) begin
            logic [3:0] dest;
            logic [3:0] op;
            dest = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'(IMEM_ID);
            op   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'(PE_BASE + $urandom_range(0, NUM_PE - 1));
            model_req(dest, op, int'($urandom_range(0, 2)));
        end
        check("total_responses", 33'(resp_total), 33'(NUM_PE * (OUT_DIM - 1)));
        check("done_flag", bus.done, 1);
        check("done_busy", bus.busy, 0);
        check("done_in_ready", bus.in_ready, 0);

        // Requests stall in DONE.
        bus.in_data  = {4'd10, 4'd5, 25'h0};
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("done_stall_out_valid", bus.out_valid, 0);
            check("done_stall_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;

        // Restart from DONE.
        run_init();

        // Reset in the middle of a response.
        bus.in_data  = {4'd10, 4'd5, 25'h0};
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("mid_out_valid", bus.out_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_ld_ready", bus.ld_ready, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        for (int k = 0; k < NUM_PE; k++) ref_cnt[k] = 0;

        // Out-of-range load, one real rewrite, then reread via a new pass.
        load_row(5'd30, 25'h1FFFFFF);
        check("bad_load_err", bus.err, CHK_EN);
        load_row(5'd3, 25'h0ABCDE);
        run_init();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
